// File: rtl/keypad_multitap_encoder.sv
// 4x4 keypad scanner, debouncer and phone-style multi-tap letter encoder.
// Optional feature: define KEYPAD_AUTO_COMMIT_EN to commit the pending letter on tap timeout.
module keypad_multitap_encoder #(
  parameter int SCAN_DIV    = 4,
  parameter int DEBOUNCE    = 8,
  parameter int TAP_TIMEOUT = 150
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [7:0] cur_char,
  output logic [7:0] letter,
  output logic       letter_strobe,
  output logic       word_strobe,
  output logic       key_error
);

  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int DW = $clog2(DEBOUNCE + 1);
  localparam int TW = $clog2(TAP_TIMEOUT + 1);
  localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);
  localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE - 1);
  localparam logic [TW-1:0] TO_LAST   = TW'(TAP_TIMEOUT - 1);
  localparam logic [3:0] K_STAR = 4'd8;
  localparam logic [3:0] K_HASH = 4'd9;
  localparam logic [3:0] K_NONE = 4'd15;

  typedef enum logic [1:0] {SCAN, DEB_PRESS, HELD, DEB_REL} state_t;

  state_t        state;
  logic [SW-1:0] scan_cnt;
  logic [DW-1:0] deb_cnt;
  logic [TW-1:0] to_cnt;
  logic [3:0]    cap_row;
  logic [3:0]    key_code_q;
  logic [3:0]    key_now;
  logic [1:0]    row_idx;
  logic [1:0]    col_idx;
  logic          key_evt;
  logic          key_valid_q;
  logic          rel_done;
  logic          to_run;
  logic          tap_open;
  logic          pend_valid;
  logic [2:0]    pend_key;
  logic [1:0]    tap_idx;

  // Letter keys are codes 0..7 (ABC..WXYZ); star and hash are special; the rest are ignored.
  function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
    case ({r, c})
      4'b00_01: key_map = 4'd0;
      4'b00_10: key_map = 4'd1;
      4'b01_00: key_map = 4'd2;
      4'b01_01: key_map = 4'd3;
      4'b01_10: key_map = 4'd4;
      4'b10_00: key_map = 4'd5;
      4'b10_01: key_map = 4'd6;
      4'b10_10: key_map = 4'd7;
      4'b11_00: key_map = K_STAR;
      4'b11_10: key_map = K_HASH;
      default:  key_map = K_NONE;
    endcase
  endfunction

  function automatic logic [7:0] char_of(input logic [2:0] k, input logic [1:0] idx);
    logic [7:0] base;
    case (k)
      3'd0:    base = 8'h41;
      3'd1:    base = 8'h44;
      3'd2:    base = 8'h47;
      3'd3:    base = 8'h4A;
      3'd4:    base = 8'h4D;
      3'd5:    base = 8'h50;
      3'd6:    base = 8'h54;
      default: base = 8'h57;
    endcase
    char_of = base + {6'b000000, idx};
  endfunction

  function automatic logic [1:0] next_idx(input logic [2:0] k, input logic [1:0] idx);
    logic [1:0] last;
    last = (k == 3'd5 || k == 3'd7) ? 2'd3 : 2'd2;
    next_idx = (idx == last) ? 2'd0 : idx + 2'd1;
  endfunction

  // Lowest-numbered row wins when several rows are high; col is frozen while a key is handled.
  always_comb begin
    row_idx = 2'd3;
    if (cap_row[3])      row_idx = 2'd0;
    else if (cap_row[2]) row_idx = 2'd1;
    else if (cap_row[1]) row_idx = 2'd2;
    col_idx = 2'd3;
    if (col[3])      col_idx = 2'd0;
    else if (col[2]) col_idx = 2'd1;
    else if (col[1]) col_idx = 2'd2;
    key_now = key_map(row_idx, col_idx);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= SCAN;
      col         <= 4'b1000;
      scan_cnt    <= '0;
      deb_cnt     <= '0;
      cap_row     <= 4'b0000;
      key_code_q  <= K_NONE;
      key_evt     <= 1'b0;
      key_valid_q <= 1'b0;
      rel_done    <= 1'b0;
    end else begin
      key_evt  <= 1'b0;
      rel_done <= 1'b0;
      case (state)
        SCAN: begin
          if (row != 4'b0000) begin
            cap_row <= row;
            deb_cnt <= '0;
            state   <= DEB_PRESS;
          end else if (scan_cnt == SCAN_LAST) begin
            scan_cnt <= '0;
            col      <= {col[0], col[3:1]};
          end else begin
            scan_cnt <= scan_cnt + 1'b1;
          end
        end
        DEB_PRESS: begin
          if (row != cap_row) begin
            scan_cnt <= '0;
            state    <= SCAN;
          end else if (deb_cnt == DEB_LAST) begin
            key_code_q  <= key_now;
            key_evt     <= (key_now != K_NONE);
            key_valid_q <= (key_now != K_NONE);
            state       <= HELD;
          end else begin
            deb_cnt <= deb_cnt + 1'b1;
          end
        end
        HELD: begin
          if (row == 4'b0000) begin
            deb_cnt <= '0;
            state   <= DEB_REL;
          end
        end
        default: begin
          if (row != 4'b0000) begin
            state <= HELD;
          end else if (deb_cnt == DEB_LAST) begin
            scan_cnt <= '0;
            rel_done <= key_valid_q;
            state    <= SCAN;
          end else begin
            deb_cnt <= deb_cnt + 1'b1;
          end
        end
      endcase
    end
  end

  // Tap state: the timeout only advances while scanning, so expiry is judged when a key is accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      cur_char      <= 8'h00;
      letter        <= 8'h00;
      letter_strobe <= 1'b0;
      word_strobe   <= 1'b0;
      key_error     <= 1'b0;
      to_cnt        <= '0;
      to_run        <= 1'b0;
      tap_open      <= 1'b0;
      pend_valid    <= 1'b0;
      pend_key      <= 3'd0;
      tap_idx       <= 2'd0;
    end else begin
      letter_strobe <= 1'b0;
      word_strobe   <= 1'b0;
      key_error     <= 1'b0;
      if (key_evt) begin
        to_run <= 1'b0;
        if (!key_code_q[3]) begin
          if (pend_valid && tap_open && pend_key == key_code_q[2:0]) begin
            tap_idx  <= next_idx(pend_key, tap_idx);
            cur_char <= char_of(pend_key, next_idx(pend_key, tap_idx));
          end else begin
            pend_key <= key_code_q[2:0];
            tap_idx  <= 2'd0;
            cur_char <= char_of(key_code_q[2:0], 2'd0);
          end
          pend_valid <= 1'b1;
          tap_open   <= 1'b1;
        end else if (key_code_q == K_STAR) begin
          if (pend_valid) begin
            letter        <= cur_char;
            letter_strobe <= 1'b1;
            pend_valid    <= 1'b0;
            tap_open      <= 1'b0;
            tap_idx       <= 2'd0;
            cur_char      <= 8'h00;
          end else begin
            key_error <= 1'b1;
          end
        end else begin
          word_strobe <= 1'b1;
          pend_valid  <= 1'b0;
          tap_open    <= 1'b0;
          tap_idx     <= 2'd0;
          cur_char    <= 8'h00;
        end
      end else if (rel_done) begin
        to_cnt <= '0;
        to_run <= 1'b1;
      end else if (to_run && state == SCAN) begin
        if (to_cnt == TO_LAST) begin
          to_run   <= 1'b0;
          tap_open <= 1'b0;
`ifdef KEYPAD_AUTO_COMMIT_EN
          if (pend_valid) begin
            letter        <= cur_char;
            letter_strobe <= 1'b1;
            pend_valid    <= 1'b0;
            tap_idx       <= 2'd0;
            cur_char      <= 8'h00;
          end
`else
          pend_valid <= pend_valid;
`endif
        end else begin
          to_cnt <= to_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_keypad_multitap_encoder.sv
// Directed bench for keypad_multitap_encoder with a behavioural keypad and a strobe scoreboard.
module tb_keypad_multitap_encoder;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] row;
  logic [3:0] col;
  logic [7:0] cur_char;
  logic [7:0] letter;
  logic       letter_strobe;
  logic       word_strobe;
  logic       key_error;

  int tests = 0;
  int fails = 0;

  logic       pressed = 1'b0;
  int         pr = 0;
  int         pc = 0;
  logic       raw_en = 1'b0;
  logic [3:0] raw_row = 4'b0000;
  logic [9:0] exp_q[$];
  logic [1:0] mon_kind;
  logic [9:0] mon_obs;
  logic [9:0] mon_exp;
  logic [3:0] col_snap;

  keypad_multitap_encoder #(.SCAN_DIV(4), .DEBOUNCE(8), .TAP_TIMEOUT(150)) dut (
    .clk(clk),
    .rst(rst),
    .row(row),
    .col(col),
    .cur_char(cur_char),
    .letter(letter),
    .letter_strobe(letter_strobe),
    .word_strobe(word_strobe),
    .key_error(key_error)
  );

  always #5 clk = ~clk;

  // The pressed key connects its row only while its column is driven.
  always_comb begin
    row = 4'b0000;
    if (raw_en) row = raw_row;
    else if (pressed && col[3-pc]) row = 4'b1000 >> pr;
  end

  task automatic check_output(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic apply_stimulus(input int r, input int c, input int hold, input int gap);
    pr = r;
    pc = c;
    pressed = 1'b1;
    cycles(hold);
    pressed = 1'b0;
    cycles(gap);
  endtask

  // Every strobe pops one expected {kind, letter} entry: 0=letter, 1=word, 2=error.
  always @(negedge clk) begin
    if (!rst && (letter_strobe || word_strobe || key_error)) begin
      case ({letter_strobe, word_strobe, key_error})
        3'b100:  mon_kind = 2'd0;
        3'b010:  mon_kind = 2'd1;
        3'b001:  mon_kind = 2'd2;
        default: mon_kind = 2'd3;
      endcase
      mon_obs = {mon_kind, (mon_kind == 2'd0) ? letter : 8'h00};
      if (exp_q.size() == 0) mon_exp = 10'h3FF;
      else mon_exp = exp_q.pop_front();
      check_output("strobe", {6'h00, mon_obs}, {6'h00, mon_exp});
    end
  end

  initial begin
    rst = 1'b1;
    cycles(3);
    check_output("reset_col", {12'h000, col}, 16'h0008);
    check_output("reset_cur_char", {8'h00, cur_char}, 16'h0000);
    check_output("reset_letter", {8'h00, letter}, 16'h0000);
    check_output("reset_strobes", {13'h0000, letter_strobe, word_strobe, key_error}, 16'h0000);
    rst = 1'b0;

    apply_stimulus(0, 1, 20, 20);
    check_output("abc_first", {8'h00, cur_char}, 16'h0041);
    exp_q.push_back({2'd0, 8'h41});
    apply_stimulus(3, 0, 30, 20);
    check_output("commit_a_clears", {8'h00, cur_char}, 16'h0000);

    apply_stimulus(1, 1, 30, 40);
    check_output("jkl_1", {8'h00, cur_char}, 16'h004A);
    apply_stimulus(1, 1, 30, 40);
    check_output("jkl_2", {8'h00, cur_char}, 16'h004B);
    apply_stimulus(1, 1, 30, 40);
    check_output("jkl_3", {8'h00, cur_char}, 16'h004C);
    exp_q.push_back({2'd0, 8'h4C});
    apply_stimulus(3, 0, 30, 20);
    check_output("commit_l_clears", {8'h00, cur_char}, 16'h0000);

    for (int i = 0; i < 4; i++) apply_stimulus(1, 1, 30, 40);
    check_output("jkl_wrap", {8'h00, cur_char}, 16'h004A);
    exp_q.push_back({2'd0, 8'h4A});
    apply_stimulus(3, 0, 30, 20);

    apply_stimulus(0, 2, 30, 40);
    check_output("def_1", {8'h00, cur_char}, 16'h0044);
    apply_stimulus(0, 2, 30, 40);
    check_output("def_2", {8'h00, cur_char}, 16'h0045);
`ifdef KEYPAD_AUTO_COMMIT_EN
    exp_q.push_back({2'd0, 8'h45});
    cycles(200);
    check_output("timeout_autocommit", {8'h00, cur_char}, 16'h0000);
`else
    cycles(200);
    check_output("timeout_keeps_pending", {8'h00, cur_char}, 16'h0045);
`endif
    apply_stimulus(0, 2, 30, 40);
    check_output("def_restart", {8'h00, cur_char}, 16'h0044);
    exp_q.push_back({2'd1, 8'h00});
    apply_stimulus(3, 2, 30, 20);
    check_output("word_discards", {8'h00, cur_char}, 16'h0000);

    raw_row = 4'b0100;
    raw_en = 1'b1;
    cycles(3);
    raw_en = 1'b0;
    cycles(1);
    col_snap = col;
    cycles(6);
    check_output("glitch_scan_resumes", {15'h0000, col !== col_snap}, 16'h0001);
    check_output("glitch_no_char", {8'h00, cur_char}, 16'h0000);
    exp_q.push_back({2'd2, 8'h00});
    apply_stimulus(3, 0, 30, 20);
    check_output("error_no_char", {8'h00, cur_char}, 16'h0000);

    apply_stimulus(2, 0, 30, 40);
    check_output("pqrs_1", {8'h00, cur_char}, 16'h0050);
    exp_q.push_back({2'd1, 8'h00});
    apply_stimulus(3, 2, 30, 20);
    check_output("word_clears", {8'h00, cur_char}, 16'h0000);
`ifdef KEYPAD_AUTO_COMMIT_EN
    check_output("letter_holds", {8'h00, letter}, 16'h0045);
`else
    check_output("letter_holds", {8'h00, letter}, 16'h004A);
`endif

    pr = 1;
    pc = 0;
    pressed = 1'b1;
    cycles(30);
    check_output("ghi_held", {8'h00, cur_char}, 16'h0047);
    rst = 1'b1;
    pressed = 1'b0;
    cycles(1);
    check_output("midreset_col", {12'h000, col}, 16'h0008);
    check_output("midreset_cur_char", {8'h00, cur_char}, 16'h0000);
    check_output("midreset_letter", {8'h00, letter}, 16'h0000);
    check_output("midreset_strobes", {13'h0000, letter_strobe, word_strobe, key_error}, 16'h0000);
    rst = 1'b0;
    cycles(30);
    check_output("after_reset_idle", {8'h00, cur_char}, 16'h0000);

    check_output("scoreboard_drained", 16'(exp_q.size()), 16'h0000);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
